// File: rtl/decode_if.sv
// Signal bundle between the decode stage and its surroundings: fetch next-PC
// controls, hazard/forwarding inputs, W-stage write port and ID/EX operands.
interface decode_if;
    logic [31:0] Instr_F;
    logic [31:0] PC_4_F;
    logic        stall;
    logic [1:0]  fwd_rs_sel;
    logic [1:0]  fwd_rt_sel;
    logic [31:0] fwd_data_E;
    logic [31:0] fwd_data_M;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;

    logic        pc_en;
    logic [1:0]  PCSrc;
    logic [31:0] ext_offset;
    logic [31:0] ext_index;
    logic [31:0] GPR_rs;
    logic [31:0] instr_D;
    logic [31:0] pc8_D;
    logic [31:0] rs_data_D;
    logic [31:0] rt_data_D;
    logic [31:0] imm32_D;

    modport master (
        output Instr_F, PC_4_F, stall, fwd_rs_sel, fwd_rt_sel,
               fwd_data_E, fwd_data_M, reg_we, reg_waddr, reg_wdata,
        input  pc_en, PCSrc, ext_offset, ext_index, GPR_rs, instr_D,
               pc8_D, rs_data_D, rt_data_D, imm32_D
    );

    modport slave (
        input  Instr_F, PC_4_F, stall, fwd_rs_sel, fwd_rt_sel,
               fwd_data_E, fwd_data_M, reg_we, reg_waddr, reg_wdata,
        output pc_en, PCSrc, ext_offset, ext_index, GPR_rs, instr_D,
               pc8_D, rs_data_D, rt_data_D, imm32_D
    );
endinterface

// File: rtl/decode_stage.sv
// Pipeline decode stage: IF/ID register, 32x32 GPR file with write-through
// bypass, operand forwarding, and branch/jump resolution for the fetch stage.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          NREG     = 32
) (
    input  logic     clk,
    input  logic     reset,
    decode_if.slave  dif
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic [31:0] gpr [NREG];

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [15:0] imm16;
    logic [31:0] rs_gpr;
    logic [31:0] rt_gpr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] sext;
    logic [31:0] zext;
    logic [1:0]  pc_src;

    // IF/ID register; no flush on taken branches, the delay slot always runs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            pc4_q   <= RESET_PC;
        end else if (!dif.stall) begin
            instr_q <= dif.Instr_F;
            pc4_q   <= dif.PC_4_F;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpr <= '{default: '0};
        end else if (dif.reg_we && dif.reg_waddr != 5'd0) begin
            gpr[dif.reg_waddr] <= dif.reg_wdata;
        end
    end

    assign op      = instr_q[31:26];
    assign rs_addr = instr_q[25:21];
    assign rt_addr = instr_q[20:16];
    assign imm16   = instr_q[15:0];
    assign funct   = instr_q[5:0];

    function automatic logic [31:0] gpr_read(input logic [4:0]  addr,
                                             input logic [31:0] stored,
                                             input logic        we,
                                             input logic [4:0]  waddr,
                                             input logic [31:0] wdata);
        if (addr == 5'd0)
            return 32'd0;
        else if (we && waddr == addr)
            return wdata;
        else
            return stored;
    endfunction

    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] reg_val,
                                            input logic [31:0] data_e,
                                            input logic [31:0] data_m);
        case (sel)
            2'd1:    return data_e;
            2'd2:    return data_m;
            default: return reg_val;
        endcase
    endfunction

    assign rs_gpr = gpr_read(rs_addr, gpr[rs_addr], dif.reg_we, dif.reg_waddr, dif.reg_wdata);
    assign rt_gpr = gpr_read(rt_addr, gpr[rt_addr], dif.reg_we, dif.reg_waddr, dif.reg_wdata);
    assign rs_val = fwd_mux(dif.fwd_rs_sel, rs_gpr, dif.fwd_data_E, dif.fwd_data_M);
    assign rt_val = fwd_mux(dif.fwd_rt_sel, rt_gpr, dif.fwd_data_E, dif.fwd_data_M);

    assign sext = {{16{imm16[15]}}, imm16};
    assign zext = {16'd0, imm16};

    always_comb begin
        pc_src = PC_SEQ;
        case (op)
            OP_BEQ:     if (rs_val == rt_val) pc_src = PC_BRANCH;
            OP_BNE:     if (rs_val != rt_val) pc_src = PC_BRANCH;
            OP_J,
            OP_JAL:     pc_src = PC_JUMP;
            OP_SPECIAL: if (funct == FN_JR || funct == FN_JALR) pc_src = PC_REG;
            default:    pc_src = PC_SEQ;
        endcase
        // a stalled decode must not redirect fetch; it is re-resolved next cycle
        if (dif.stall)
            pc_src = PC_SEQ;
    end

    assign dif.pc_en      = ~dif.stall;
    assign dif.PCSrc      = pc_src;
    assign dif.ext_offset = sext;
    assign dif.ext_index  = {pc4_q[31:28], instr_q[25:0], 2'b00};
    assign dif.GPR_rs     = rs_val;
    assign dif.instr_D    = instr_q;
    assign dif.pc8_D      = pc4_q + 32'd4;
    assign dif.rs_data_D  = rs_val;
    assign dif.rt_data_D  = rt_val;
    assign dif.imm32_D    = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? zext : sext;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus queues expected outputs, a
// separate monitor samples the DUT and compares against the queue.
module tb_decode_stage;
    localparam int F_INSTR = 0;
    localparam int F_PCSRC = 1;
    localparam int F_EOFF  = 2;
    localparam int F_EIDX  = 3;
    localparam int F_GRS   = 4;
    localparam int F_PC8   = 5;
    localparam int F_RS    = 6;
    localparam int F_RT    = 7;
    localparam int F_IMM   = 8;
    localparam int F_PCEN  = 9;
    localparam int NF      = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_if dif();
    decode_stage dut (.clk(clk), .reset(reset), .dif(dif));

    string fname [NF] = '{"instr_D", "PCSrc", "ext_offset", "ext_index", "GPR_rs",
                          "pc8_D", "rs_data_D", "rt_data_D", "imm32_D", "pc_en"};

    string         q_name [$];
    logic [NF-1:0] q_mask [$];
    logic [319:0]  q_val  [$];

    string         cur_name;
    logic [NF-1:0] cur_mask;
    logic [319:0]  cur_val;

    int checks = 0;
    int errors = 0;
    event sample_ev;

    task automatic exp_begin(input string nm);
        cur_name = nm;
        cur_mask = '0;
        cur_val  = '0;
    endtask

    task automatic want(input int f, input logic [31:0] v);
        cur_val[f*32 +: 32] = v;
        cur_mask[f] = 1'b1;
    endtask

    task automatic push();
        #1;
        q_name.push_back(cur_name);
        q_mask.push_back(cur_mask);
        q_val.push_back(cur_val);
        -> sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        string         nm;
        logic [NF-1:0] m;
        logic [319:0]  v;
        logic [319:0]  act;
        forever begin
            @(sample_ev);
            while (q_name.size() > 0) begin
                nm = q_name.pop_front();
                m  = q_mask.pop_front();
                v  = q_val.pop_front();
                act = '0;
                act[F_INSTR*32 +: 32] = dif.instr_D;
                act[F_PCSRC*32 +: 32] = {30'd0, dif.PCSrc};
                act[F_EOFF*32  +: 32] = dif.ext_offset;
                act[F_EIDX*32  +: 32] = dif.ext_index;
                act[F_GRS*32   +: 32] = dif.GPR_rs;
                act[F_PC8*32   +: 32] = dif.pc8_D;
                act[F_RS*32    +: 32] = dif.rs_data_D;
                act[F_RT*32    +: 32] = dif.rt_data_D;
                act[F_IMM*32   +: 32] = dif.imm32_D;
                act[F_PCEN*32  +: 32] = {31'd0, dif.pc_en};
                for (int i = 0; i < NF; i++) begin
                    if (m[i]) begin
                        checks++;
                        if (act[i*32 +: 32] !== v[i*32 +: 32]) begin
                            errors++;
                            $display("FAIL %s.%s got %h want %h", nm, fname[i],
                                     act[i*32 +: 32], v[i*32 +: 32]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        dif.Instr_F = '0;    dif.PC_4_F = '0;     dif.stall = 1'b0;
        dif.fwd_rs_sel = '0; dif.fwd_rt_sel = '0;
        dif.fwd_data_E = '0; dif.fwd_data_M = '0;
        dif.reg_we = 1'b0;   dif.reg_waddr = '0;  dif.reg_wdata = '0;
        #12 reset = 1'b0;

        exp_begin("reset");
        want(F_INSTR, 32'h0); want(F_PC8, 32'h3004); want(F_PCSRC, 0); want(F_PCEN, 1);
        push();

        dif.Instr_F = 32'h3401_0005; dif.PC_4_F = 32'h3004;
        tick();
        exp_begin("ori");
        want(F_INSTR, 32'h3401_0005); want(F_IMM, 32'h5); want(F_PCSRC, 0);
        want(F_PC8, 32'h3008); want(F_EOFF, 32'h5);
        push();

        dif.Instr_F = 32'h3444_1234; dif.PC_4_F = 32'h3008;
        tick();
        dif.reg_we = 1'b1; dif.reg_waddr = 5'd2; dif.reg_wdata = 32'hDEAD_BEEF;
        exp_begin("bypass");
        want(F_RS, 32'hDEAD_BEEF); want(F_RT, 32'h0); want(F_IMM, 32'h0000_1234);
        push();
        tick();
        dif.reg_we = 1'b0;
        exp_begin("gpr_written");
        want(F_RS, 32'hDEAD_BEEF);
        push();

        dif.Instr_F = 32'h3400_0000;
        tick();
        dif.reg_we = 1'b1; dif.reg_waddr = 5'd0; dif.reg_wdata = 32'hFFFF_FFFF;
        exp_begin("zero_bypass");
        want(F_RS, 32'h0); want(F_RT, 32'h0);
        push();
        tick();
        dif.reg_we = 1'b0;
        exp_begin("zero_after_write");
        want(F_RS, 32'h0);
        push();

        dif.Instr_F = 32'h1022_FFFC; dif.PC_4_F = 32'h300C;
        dif.reg_we = 1'b1; dif.reg_waddr = 5'd1; dif.reg_wdata = 32'd7;
        tick();
        dif.reg_waddr = 5'd2; dif.reg_wdata = 32'd7;
        tick();
        dif.reg_we = 1'b0;
        exp_begin("beq_taken");
        want(F_PCSRC, 1); want(F_EOFF, 32'hFFFF_FFFC); want(F_RS, 32'd7);
        want(F_RT, 32'd7); want(F_IMM, 32'hFFFF_FFFC);
        push();
        dif.reg_we = 1'b1; dif.reg_waddr = 5'd2; dif.reg_wdata = 32'd8;
        exp_begin("beq_not_taken");
        want(F_PCSRC, 0); want(F_RT, 32'd8);
        push();

        dif.Instr_F = 32'h1422_FFFC;
        tick();
        dif.reg_we = 1'b0;
        exp_begin("bne_taken");
        want(F_PCSRC, 1); want(F_RT, 32'd8); want(F_EOFF, 32'hFFFF_FFFC);
        push();
        dif.fwd_rt_sel = 2'd2; dif.fwd_data_M = 32'd7;
        exp_begin("bne_fwd_m_equal");
        want(F_PCSRC, 0); want(F_RT, 32'd7);
        push();
        dif.fwd_rt_sel = 2'd3;
        exp_begin("bne_sel3_gpr");
        want(F_PCSRC, 1); want(F_RT, 32'd8);
        push();
        dif.fwd_rt_sel = 2'd0;

        dif.Instr_F = 32'h0800_0C01; dif.PC_4_F = 32'h3010;
        tick();
        exp_begin("j");
        want(F_PCSRC, 2); want(F_EIDX, 32'h0000_3004); want(F_PC8, 32'h3014);
        push();

        dif.Instr_F = 32'h03E0_0008; dif.PC_4_F = 32'h3014;
        dif.fwd_rs_sel = 2'd1; dif.fwd_data_E = 32'h3100;
        tick();
        exp_begin("jr_fwd_e");
        want(F_PCSRC, 3); want(F_GRS, 32'h3100); want(F_RS, 32'h3100);
        push();
        dif.fwd_rs_sel = 2'd0;
        exp_begin("jr_gpr");
        want(F_PCSRC, 3); want(F_GRS, 32'h0);
        push();

        dif.Instr_F = 32'h03E0_F809; dif.PC_4_F = 32'h3018;
        dif.fwd_rs_sel = 2'd2; dif.fwd_data_M = 32'h4444;
        tick();
        exp_begin("jalr_fwd_m");
        want(F_PCSRC, 3); want(F_GRS, 32'h4444); want(F_PC8, 32'h301C);
        push();

        dif.stall = 1'b1; dif.Instr_F = 32'h3000_8000; dif.PC_4_F = 32'h301C;
        exp_begin("stall_0");
        want(F_INSTR, 32'h03E0_F809); want(F_PCSRC, 0); want(F_PCEN, 0);
        push();
        tick();
        exp_begin("stall_1");
        want(F_INSTR, 32'h03E0_F809); want(F_PCSRC, 0); want(F_PCEN, 0);
        want(F_PC8, 32'h301C);
        push();
        tick();
        exp_begin("stall_2");
        want(F_INSTR, 32'h03E0_F809); want(F_PCSRC, 0); want(F_PCEN, 0);
        want(F_PC8, 32'h301C);
        push();
        dif.stall = 1'b0;
        exp_begin("stall_release");
        want(F_INSTR, 32'h03E0_F809); want(F_PCSRC, 3); want(F_PCEN, 1);
        push();
        tick();
        dif.fwd_rs_sel = 2'd0;
        exp_begin("andi_captured");
        want(F_INSTR, 32'h3000_8000); want(F_IMM, 32'h0000_8000);
        want(F_PC8, 32'h3020); want(F_PCSRC, 0); want(F_EOFF, 32'hFFFF_8000);
        push();

        dif.Instr_F = 32'h2400_8000; dif.PC_4_F = 32'h3020;
        tick();
        exp_begin("addiu_sext");
        want(F_IMM, 32'hFFFF_8000); want(F_INSTR, 32'h2400_8000);
        push();

        dif.stall = 1'b1;
        #1 reset = 1'b1;
        exp_begin("async_reset");
        want(F_INSTR, 32'h0); want(F_PC8, 32'h3004); want(F_PCSRC, 0);
        push();
        dif.Instr_F = 32'h1022_FFFC; dif.PC_4_F = 32'h3004;
        reset = 1'b0; dif.stall = 1'b0;
        tick();
        exp_begin("gprs_cleared");
        want(F_INSTR, 32'h1022_FFFC); want(F_RS, 32'h0); want(F_RT, 32'h0);
        want(F_PCSRC, 1);
        push();

        #5;
        if (q_name.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q_name.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
